systolic_seq_ctrl: RTL
======================

Name: systolic_seq_ctrl

Overview:
- Sequencer for an ARRAY_N x ARRAY_N output-stationary systolic array of MAC cells.
- Accepts one matrix-multiply job (reduction depth k_len) per start and clears the accumulators.
- Drives the broadcast acc_rst/acc_en/shift enables, and gives the skew feeders a step counter.
- Holds results stable until the consumer acknowledges them.

Parameters:
- ARRAY_N, 4, array rows/columns (>=2).
- K_MAX, 16, maximum reduction depth accepted (>=1).
- CNT_W, $clog2(K_MAX+2*ARRAY_N), width of k_len and step counter.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  job request; sampled only in IDLE.
- k_len  in  CNT_W  reduction depth; latched with start.
- abort  in  1  synchronous job cancel.
- res_ack  in  1  consumer has read accumulators.
- busy  out  1  high in every state except IDLE.
- done  out  1  level; results valid and frozen.
- cfg_err  out  1  one-cycle pulse: k_len clamped.
- acc_rst  out  1  broadcast accumulator clear.
- acc_en  out  1  broadcast accumulate enable.
- shift_en_right  out  1  broadcast A-operand shift.
- shift_en_down  out  1  broadcast B-operand shift.
- feed_step  out  CNT_W  current RUN step t; feeders present A[i][t-i] / B[t-j][j], else zero.
- feed_len  out  CNT_W  latched (clamped) k_len.

Behaviour:
- Clock: single clock, clk. Reset: rst, synchronous and active-high.
- Reset: state=IDLE. All outputs 0, including the latched k and the step counter.
- FSM states:
  - IDLE -> CLEAR on start & !abort. Latch k = min(k_len, K_MAX). If k_len > K_MAX, pulse cfg_err in the CLEAR cycle.
  - CLEAR: exactly 1 cycle. acc_rst=1; acc_en and shifts 0. Next state is RUN, or DONE if k==0.
  - RUN: exactly k+2*(ARRAY_N-1) cycles. acc_en = shift_en_right = shift_en_down = 1. feed_step counts 0,1,... and is held at 0 outside RUN.
  - RUN -> DONE after the cycle in which feed_step == k+2*(ARRAY_N-1)-1.
  - DONE: done=1. acc_en, shifts and acc_rst all 0, so the accumulators are frozen. DONE -> IDLE on res_ack; done drops the same edge.
- abort: in CLEAR, RUN or DONE, goes to IDLE at the next edge. done is not asserted. feed_step returns to 0. Accumulator contents are undefined after abort.
- Latency: start at edge E gives busy=1 and acc_rst=1 from E+1. First acc_en at E+2. done at E+2+k+2*(ARRAY_N-1).
  - For k=0: done at E+2.
- Boundary conditions:
  - start outside IDLE is ignored; no queueing.
  - start & abort together in IDLE: abort wins, stay IDLE.
  - res_ack outside DONE is ignored.
  - res_ack & abort together in DONE: go to IDLE.
  - k_len changes after latch have no effect.
  - A new start is accepted in IDLE on the cycle after done falls; back-to-back jobs therefore have a 1-cycle IDLE gap minimum.
  - rst mid-RUN forces the reset state the next edge. No done, no cfg_err.
- Arithmetic: step counter compare uses CNT_W bits. CNT_W covers K_MAX+2*(ARRAY_N-1) without wrap.

Optional Feature:
- Macro: SYSTOLIC_SEQ_CTRL_PERF_EN.
- When defined, the block adds outputs perf_jobs [31:0] and perf_busy_cycles [31:0].
  - perf_jobs: count of jobs reaching DONE (counted on the DONE entry edge).
  - perf_busy_cycles: count of cycles with busy=1.
  - Both counters are cleared by rst, saturate at all-ones, and ignore abort (aborted cycles still count as busy).
- When not defined, neither the ports nor the logic exist. Core behaviour is identical in both builds.

Test Plan:
- Normal job (ARRAY_N=4, k_len=3, start at edge E): acc_rst at E+1 only; acc_en high exactly 9 cycles (E+2..E+10) with feed_step 0..8; done at E+11 and held until res_ack; busy low the edge after ack.
- k_len=0: one acc_rst cycle, then done at E+2; acc_en never asserted.
- k_len=20 with K_MAX=16: cfg_err pulses 1 cycle at E+1; feed_len=16; RUN lasts 22 cycles.
- abort at RUN step 4: IDLE next edge; done never asserted; feed_step=0. A start issued 1 cycle later runs a full job normally.
- start pulses during RUN and DONE, and res_ack during RUN: all ignored; cycle counts unchanged. Simultaneous start+abort in IDLE: stays IDLE.
- rst asserted mid-RUN: all outputs 0 next edge. With SYSTOLIC_SEQ_CTRL_PERF_EN, two completed k=3 jobs give perf_jobs=2 and perf_busy_cycles=2*(1+9+DONE cycles).

Source files
------------

// File: rtl/systolic_seq_ctrl.sv
// systolic_seq_ctrl: sequencer for an ARRAY_N x ARRAY_N output-stationary
// systolic MAC array. Each job clears the accumulators for one cycle, then
// runs k + 2*(ARRAY_N-1) accumulate/shift cycles so that the skewed operand
// wavefront fully drains. Results stay frozen in DONE until res_ack.
// Optional build macro: SYSTOLIC_SEQ_CTRL_PERF_EN adds the perf_jobs and
// perf_busy_cycles counters.
module systolic_seq_ctrl #(
    parameter int ARRAY_N = 4,
    parameter int K_MAX   = 16,
    parameter int CNT_W   = $clog2(K_MAX + 2 * ARRAY_N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] k_len,
    input  logic             abort,
    input  logic             res_ack,
    output logic             busy,
    output logic             done,
    output logic             cfg_err,
    output logic             acc_rst,
    output logic             acc_en,
    output logic             shift_en_right,
    output logic             shift_en_down,
    output logic [CNT_W-1:0] feed_step,
    output logic [CNT_W-1:0] feed_len
`ifdef SYSTOLIC_SEQ_CTRL_PERF_EN
    ,
    output logic [31:0]      perf_jobs,
    output logic [31:0]      perf_busy_cycles
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] K_MAX_C = CNT_W'(K_MAX);
    // Skew drain length minus one: the last RUN step is k + SKEW_M1.
    localparam logic [CNT_W-1:0] SKEW_M1 = CNT_W'(2 * (ARRAY_N - 1) - 1);

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] k_reg, k_next;
    logic [CNT_W-1:0] step_reg, step_next;
    logic             cfg_err_reg, cfg_err_next;

    logic             k_over;
    logic [CNT_W-1:0] k_clamped;
    logic [CNT_W-1:0] run_last;

    assign k_over    = (k_len > K_MAX_C);
    assign k_clamped = k_over ? K_MAX_C : k_len;
    // Only used in RUN, where k_reg + SKEW_M1 never exceeds the counter range.
    assign run_last  = k_reg + SKEW_M1;

    // State, latched depth, step counter and clamp flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            k_reg       <= '0;
            step_reg    <= '0;
            cfg_err_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            k_reg       <= k_next;
            step_reg    <= step_next;
            cfg_err_reg <= cfg_err_next;
        end
    end

    // Next-state logic; abort always wins over start/res_ack.
    always_comb begin
        state_next   = state_reg;
        k_next       = k_reg;
        step_next    = step_reg;
        cfg_err_next = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                step_next = '0;
                if (start && !abort) begin
                    state_next   = ST_CLEAR;
                    k_next       = k_clamped;
                    cfg_err_next = k_over;
                end
            end
            ST_CLEAR: begin
                step_next = '0;
                if (abort)
                    state_next = ST_IDLE;
                else if (k_reg == '0)
                    state_next = ST_DONE;
                else
                    state_next = ST_RUN;
            end
            ST_RUN: begin
                if (abort) begin
                    state_next = ST_IDLE;
                    step_next  = '0;
                end else if (step_reg == run_last) begin
                    state_next = ST_DONE;
                    step_next  = '0;
                end else begin
                    step_next = step_reg + CNT_W'(1);
                end
            end
            ST_DONE: begin
                step_next = '0;
                if (abort || res_ack)
                    state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
                step_next  = '0;
            end
        endcase
    end

    // Moore outputs decoded from the current state.
    always_comb begin
        busy           = (state_reg != ST_IDLE);
        done           = (state_reg == ST_DONE);
        acc_rst        = (state_reg == ST_CLEAR);
        acc_en         = (state_reg == ST_RUN);
        shift_en_right = (state_reg == ST_RUN);
        shift_en_down  = (state_reg == ST_RUN);
        cfg_err        = cfg_err_reg;
        feed_step      = step_reg;
        feed_len       = k_reg;
    end

`ifdef SYSTOLIC_SEQ_CTRL_PERF_EN
    logic perf_job_inc;
    assign perf_job_inc = (state_next == ST_DONE) && (state_reg != ST_DONE);

    // Saturating job and busy-cycle counters; aborted work still counts as busy.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_jobs        <= '0;
            perf_busy_cycles <= '0;
        end else begin
            if (perf_job_inc && (perf_jobs != '1))
                perf_jobs <= perf_jobs + 32'd1;
            if (busy && (perf_busy_cycles != '1))
                perf_busy_cycles <= perf_busy_cycles + 32'd1;
        end
    end
`endif

endmodule
